// File: rtl/p_fxp_div.sv
// Sequential radix-2 restoring fixed-point divider: out = in1 / in2, one quotient bit per cycle.
// The dividend, divisor and quotient formats are independently configurable through dconf_t.
package p_fxp_div_pkg;
   typedef struct packed {
      logic       sign;
      logic [7:0] prec;
      logic [7:0] frac;
   } dconf_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP '{sign: 1'b1, prec: 8'd16, frac: 8'd8}
`endif

module p_fxp_div
   import p_fxp_div_pkg::*;
#(
   parameter dconf_t I1_CONF = `DEF_DCONF_FXP,
   parameter dconf_t I2_CONF = `DEF_DCONF_FXP,
   parameter dconf_t O_CONF  = `DEF_DCONF_FXP,
   parameter int     I1_PREC = int'(I1_CONF.prec),
   parameter int     I2_PREC = int'(I2_CONF.prec),
   parameter int     O_PREC  = int'(O_CONF.prec)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [I1_PREC-1:0] in1,
   input  logic [I2_PREC-1:0] in2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [O_PREC-1:0]  out,
   output logic               udf,
   output logic               ovf,
   output logic               rounded,
   output logic               dz
);

   localparam int SH  = int'(O_CONF.frac) - int'(I1_CONF.frac) + int'(I2_CONF.frac);
   localparam int SHC = (SH < 0) ? 0 : SH;
   localparam int N   = I1_PREC + SHC;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   // Quotient comparisons run one bit wider than both the quotient and the output word.
   localparam int QW  = ((N > O_PREC) ? N : O_PREC) + 1;

   localparam logic I1_S = I1_CONF.sign;
   localparam logic I2_S = I2_CONF.sign;
   localparam logic O_S  = O_CONF.sign;

   localparam logic [QW-1:0] NEG_LIM = QW'(1) << (O_PREC - 1);
   localparam logic [QW-1:0] POS_MAX = O_S ? (NEG_LIM - QW'(1)) : ((QW'(1) << O_PREC) - QW'(1));
   localparam logic [O_PREC-1:0] POS_MAX_O = POS_MAX[O_PREC-1:0];
   localparam logic [O_PREC-1:0] NEG_MIN_O = O_S ? NEG_LIM[O_PREC-1:0] : '0;

   generate
      if (SH < 0) begin : g_bad_shift
         $error("p_fxp_div: O_CONF.frac - I1_CONF.frac + I2_CONF.frac must be >= 0");
      end
   endgenerate

   state_t state;
   state_t state_nx;

   logic [CW-1:0]      cnt;
   logic [N-1:0]       num;
   logic [N-1:0]       quo;
   logic [I2_PREC:0]   rem;
   logic [I2_PREC-1:0] mag2;
   logic               neg;
   logic               s1;

   logic               sign1, sign2;
   logic [I1_PREC-1:0] abs1;
   logic [I2_PREC-1:0] abs2;
   logic [I2_PREC:0]   rem_sh, rem_nx;
   logic               sub_ok;
   logic [N-1:0]       quo_nx;
   logic [QW-1:0]      q_ext;
   logic [O_PREC-1:0]  res_out;
   logic               res_udf, res_ovf, res_rnd, res_dz;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (in_valid)  state_nx = ST_CALC;
         ST_CALC: if (cnt == '0) state_nx = ST_DONE;
         ST_DONE: if (out_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Handshake outputs decode straight from the state register
   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
   end

   // Operand magnitudes; -2^(P-1) maps to 2^(P-1) because the magnitude is read as unsigned.
   always_comb begin
      sign1 = I1_S ? in1[I1_PREC-1] : 1'b0;
      sign2 = I2_S ? in2[I2_PREC-1] : 1'b0;
      abs1  = sign1 ? -in1 : in1;
      abs2  = sign2 ? -in2 : in2;
   end

   always_comb begin
      rem_sh = (rem << 1) | {{I2_PREC{1'b0}}, num[N-1]};
      sub_ok = (rem_sh >= {1'b0, mag2});
      rem_nx = sub_ok ? (rem_sh - {1'b0, mag2}) : rem_sh;
      quo_nx = (quo << 1) | {{(N-1){1'b0}}, sub_ok};
   end

   // Result formatting from the quotient and remainder of the final step
   always_comb begin
      q_ext   = {{(QW-N){1'b0}}, quo_nx};
      res_out = '0;
      res_udf = 1'b0;
      res_ovf = 1'b0;
      res_dz  = 1'b0;
      res_rnd = |rem_nx;
      if (mag2 == '0) begin
         res_dz  = 1'b1;
         res_rnd = 1'b0;
         res_out = s1 ? NEG_MIN_O : POS_MAX_O;
      end else if (!neg) begin
         if (q_ext > POS_MAX) begin
            res_out = POS_MAX_O;
            res_ovf = 1'b1;
         end else begin
            res_out = q_ext[O_PREC-1:0];
         end
      end else if (O_S) begin
         if (q_ext > NEG_LIM) begin
            res_out = NEG_MIN_O;
            res_udf = 1'b1;
         end else begin
            res_out = -q_ext[O_PREC-1:0];
         end
      end else begin
         res_udf = |quo_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         num     <= '0;
         quo     <= '0;
         rem     <= '0;
         mag2    <= '0;
         neg     <= 1'b0;
         s1      <= 1'b0;
         out     <= '0;
         udf     <= 1'b0;
         ovf     <= 1'b0;
         rounded <= 1'b0;
         dz      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  num  <= N'(abs1) << SHC;
                  quo  <= '0;
                  rem  <= '0;
                  mag2 <= abs2;
                  neg  <= sign1 ^ sign2;
                  s1   <= sign1;
                  cnt  <= CW'(N - 1);
               end
            end
            ST_CALC: begin
               num <= num << 1;
               quo <= quo_nx;
               rem <= rem_nx;
               if (cnt == '0) begin
                  out     <= res_out;
                  udf     <= res_udf;
                  ovf     <= res_ovf;
                  rounded <= res_rnd;
                  dz      <= res_dz;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_p_fxp_div.sv
// Bench for p_fxp_div in the default Q8.8 signed formats: vector table, model-checked
// random operands, latency, back-pressure and mid-calculation reset sequences.
module tb_p_fxp_div;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in1, in2, out;
   logic        udf, ovf, rounded, dz;

   int n_checks = 0;
   int n_fail   = 0;

   // {out, udf, ovf, rounded, dz}
   logic [19:0] exp_q[$];

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [19:0] exp;
   } vec_t;

   vec_t vecs[$];

   p_fxp_div dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .udf       (udf),
      .ovf       (ovf),
      .rounded   (rounded),
      .dz        (dz)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [19:0] pack(input logic [15:0] o, input logic u, input logic v,
                                        input logic r, input logic d);
      return {o, u, v, r, d};
   endfunction

   // Reference: exact integer division of |a|*2^8 by |b|, then saturation by sign.
   function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint num, den, q, r;
      logic   rn;
      if (sb == 0) return pack((sa < 0) ? 16'h8000 : 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
      num = ((sa < 0) ? -sa : sa) * 256;
      den = (sb < 0) ? -sb : sb;
      q   = num / den;
      r   = num % den;
      rn  = (r != 0);
      if ((sa < 0) != (sb < 0)) begin
         if (q > 32768) return pack(16'h8000, 1'b1, 1'b0, rn, 1'b0);
         return pack(16'(-q), 1'b0, 1'b0, rn, 1'b0);
      end
      if (q > 32767) return pack(16'h7FFF, 1'b0, 1'b1, rn, 1'b0);
      return pack(16'(q), 1'b0, 1'b0, rn, 1'b0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Scoreboard: compares each result as it is transferred
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            check("result", {12'd0, out, udf, ovf, rounded, dz}, {12'd0, e});
         end
      end
   end

   // Holds in_valid until the divider is idle; operands are scrambled right after acceptance.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [19:0] e);
      int t = 0;
      @(negedge clk);
      in1      = a;
      in2      = b;
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'd1, 32'd0);
      end else begin
         @(posedge clk);
         exp_q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in1      = 16'($urandom);
      in2      = 16'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 60);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   initial begin
      int lat;
      int stray;
      logic [15:0] ra, rb;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in1       = '0;
      in2       = '0;

      vecs.push_back('{16'h0300, 16'h0200, pack(16'h0180, 0, 0, 0, 0)});
      vecs.push_back('{16'hFF00, 16'h0300, pack(16'hFFAB, 0, 0, 1, 0)});
      vecs.push_back('{16'h6400, 16'h0001, pack(16'h7FFF, 0, 1, 0, 0)});
      vecs.push_back('{16'h9C00, 16'h0001, pack(16'h8000, 1, 0, 0, 0)});
      vecs.push_back('{16'h0100, 16'h0000, pack(16'h7FFF, 0, 0, 0, 1)});
      vecs.push_back('{16'hFF00, 16'h0000, pack(16'h8000, 0, 0, 0, 1)});
      vecs.push_back('{16'h0000, 16'h0000, pack(16'h7FFF, 0, 0, 0, 1)});
      vecs.push_back('{16'h8000, 16'hFF00, pack(16'h7FFF, 0, 1, 0, 0)});
      vecs.push_back('{16'h8000, 16'h0100, pack(16'h8000, 0, 0, 0, 0)});
      vecs.push_back('{16'h0000, 16'hFF00, pack(16'h0000, 0, 0, 0, 0)});
      vecs.push_back('{16'h0100, 16'h0300, pack(16'h0055, 0, 0, 1, 0)});
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(1, 16'h0600));
         if (i % 2 == 1) rb = -rb;
         vecs.push_back('{ra, rb, model(ra, rb)});
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_outputs", {12'd0, out, udf, ovf, rounded, dz}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic divide with exact latency
      send(16'h0300, 16'h0200, pack(16'h0180, 0, 0, 0, 0));
      wait_valid(lat);
      check("latency_basic", lat, 32'd24);
      drain();

      for (int i = 0; i < vecs.size(); i++) send(vecs[i].a, vecs[i].b, vecs[i].exp);
      drain();

      // Back-pressure: result and flags held, no new acceptance
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(16'h0300, 16'h0200, pack(16'h0180, 0, 0, 0, 0));
      wait_valid(lat);
      check("latency_bp", lat, 32'd24);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold", {12'd0, out, udf, ovf, rounded, dz}, {12'd0, pack(16'h0180, 0, 0, 0, 0)});
         check("bp_valid", {30'd0, out_valid, in_ready}, 32'd2);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
      send(16'h0100, 16'h0300, model(16'h0100, 16'h0300));
      drain();

      // Reset in the middle of a calculation
      send(16'h6400, 16'h0003, model(16'h6400, 16'h0003));
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("midreset_handshake", {30'd0, out_valid, in_ready}, 32'd1);
      check("midreset_outputs", {12'd0, out, udf, ovf, rounded, dz}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stray = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) stray++;
      end
      check("midreset_no_result", stray, 32'd0);
      send(16'h0300, 16'h0200, pack(16'h0180, 0, 0, 0, 0));
      wait_valid(lat);
      check("latency_after_reset", lat, 32'd24);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
